axis_packet_checker_400g: RTL and testbench

- AXI4-Stream sink and checker at the master (output) side of the 400G AXIS data FIFO path.
- The packet generator drives an incrementing-count pattern into the FIFO; this block consumes the FIFO output and applies optional pseudo-random backpressure.
- It verifies every packet against the generator's pattern and keeps good-packet and bad-packet counts plus sticky error flags for the register map and for simulation.

---
 rtl/axis_400g_pkg.sv | 23 ++
 rtl/axis_lfsr16.sv | 27 ++
 rtl/axis_packet_checker_400g.sv | 175 +++++++++++++++++
 tb/tb_axis_packet_checker_400g.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_400g_pkg.sv
// Shared constants, state encoding and LFSR helper for the 400G AXIS checker.
package axis_400g_pkg;

    localparam int C_AXIS_DATA_WIDTH = 1024;

    localparam int ERR_W     = 5;
    localparam int ERR_DATA  = 0;
    localparam int ERR_KEEP  = 1;
    localparam int ERR_USER  = 2;
    localparam int ERR_SHORT = 3;
    localparam int ERR_LONG  = 4;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BODY = 1'b1
    } pkt_state_e;

    // 16-bit Fibonacci step, taps 16,14,13,11 (bit indices 15,13,12,10).
    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/axis_lfsr16.sv
// 16-bit Fibonacci LFSR with reset seed and step enable.
module axis_lfsr16 #(
    parameter logic [15:0] G_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] state
);
    import axis_400g_pkg::*;

    logic [15:0] state_r;

    // Reload the seed on reset, otherwise shift one step per enabled cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= G_SEED;
        end else if (en) begin
            state_r <= lfsr16_next(state_r);
        end else begin
            state_r <= state_r;
        end
    end

    assign state = state_r;

endmodule

// File: rtl/axis_packet_checker_400g.sv
// AXI4-Stream sink that checks incrementing-count packets and keeps statistics.
module axis_packet_checker_400g
    import axis_400g_pkg::*;
#(
    parameter int          G_AXIS_DATA_WIDTH = C_AXIS_DATA_WIDTH,
    parameter int          G_PKT_BEATS       = 64,
    parameter int          G_CNT_WIDTH       = 32,
    parameter logic [15:0] G_LFSR_SEED       = 16'hACE1
) (
    input  logic                           axis_aclk,
    input  logic                           axis_aresetn,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic [G_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [G_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                           s_axis_tlast,
    input  logic                           s_axis_tuser,
    input  logic                           throttle_en,
    input  logic                           clr_stats,
    output logic [G_CNT_WIDTH-1:0]         good_pkt_cnt,
    output logic [G_CNT_WIDTH-1:0]         bad_pkt_cnt,
    output logic [ERR_W-1:0]               err_flags,
    output logic                           pkt_done
);

    localparam logic [G_CNT_WIDTH-1:0] CNT_ONE  = {{(G_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [15:0]            PKT_LEN  = 16'(G_PKT_BEATS);
    localparam logic [16:0]            PKT_LEN17 = 17'(G_PKT_BEATS);

    logic [15:0]            lfsr_s;
    logic                   lfsr_unused_s;
    logic                   tready_r;
    logic                   accept_s;
    pkt_state_e             state_r, state_nxt_s;
    logic [15:0]            beat_cnt_r, beat_cnt_nxt_s, beat_cnt_inc_s, exp_s;
    logic [16:0]            total_s;
    logic [ERR_W-1:0]       beat_err_s, acc_err_s, pkt_err_r, pkt_err_nxt_s;
    logic [ERR_W-1:0]       close_err_s, close_err_r;
    logic                   close_s, close_pend_r;
    logic [G_CNT_WIDTH-1:0] good_r, bad_r;
    logic [ERR_W-1:0]       flags_r;
    logic                   done_r;

    axis_lfsr16 #(.G_SEED(G_LFSR_SEED)) u_lfsr (
        .clk   (axis_aclk),
        .rst_n (axis_aresetn),
        .en    (1'b1),
        .state (lfsr_s)
    );

    assign lfsr_unused_s = ^lfsr_s[15:1];
    assign accept_s      = s_axis_tvalid & tready_r;

    // Backpressure: registered ready from the LFSR or held high
    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            tready_r <= 1'b0;
        end else if (throttle_en) begin
            tready_r <= lfsr_s[0];
        end else begin
            tready_r <= 1'b1;
        end
    end

    // Per-beat checks, packet error accumulation and next-state decode
    always_comb begin
        state_nxt_s    = state_r;
        beat_cnt_nxt_s = beat_cnt_r;
        pkt_err_nxt_s  = pkt_err_r;
        close_s        = 1'b0;
        close_err_s    = {ERR_W{1'b0}};
        acc_err_s      = {ERR_W{1'b0}};
        beat_err_s     = {ERR_W{1'b0}};

        // A packet's first beat is always expected to carry 0.
        if (state_r == S_BODY) begin
            exp_s = beat_cnt_r;
        end else begin
            exp_s = 16'd0;
        end

        if (beat_cnt_r == 16'hFFFF) begin
            beat_cnt_inc_s = 16'hFFFF;
        end else begin
            beat_cnt_inc_s = beat_cnt_r + 16'd1;
        end

        total_s = {1'b0, exp_s} + 17'd1;

        beat_err_s[ERR_DATA] = (s_axis_tdata != G_AXIS_DATA_WIDTH'(exp_s));
        beat_err_s[ERR_KEEP] = ~(&s_axis_tkeep);
        beat_err_s[ERR_USER] = s_axis_tuser;
        beat_err_s[ERR_LONG] = (state_r == S_BODY) && (beat_cnt_r == PKT_LEN);

        if (accept_s) begin
            case (state_r)
                S_IDLE: begin
                    beat_cnt_nxt_s = 16'd1;
                    acc_err_s      = beat_err_s;
                end
                S_BODY: begin
                    beat_cnt_nxt_s = beat_cnt_inc_s;
                    acc_err_s      = pkt_err_r | beat_err_s;
                end
                default: begin
                    beat_cnt_nxt_s = 16'd1;
                    acc_err_s      = beat_err_s;
                end
            endcase

            if (s_axis_tlast) begin
                close_s                = 1'b1;
                close_err_s            = acc_err_s;
                close_err_s[ERR_SHORT] = (total_s < PKT_LEN17);
                state_nxt_s            = S_IDLE;
                beat_cnt_nxt_s         = 16'd0;
                pkt_err_nxt_s          = {ERR_W{1'b0}};
            end else begin
                state_nxt_s   = S_BODY;
                pkt_err_nxt_s = acc_err_s;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM state, beat counter, packet error register and close pipeline stage
    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            state_r      <= S_IDLE;
            beat_cnt_r   <= 16'd0;
            pkt_err_r    <= {ERR_W{1'b0}};
            close_pend_r <= 1'b0;
            close_err_r  <= {ERR_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            beat_cnt_r   <= beat_cnt_nxt_s;
            pkt_err_r    <= pkt_err_nxt_s;
            close_pend_r <= close_s;
            close_err_r  <= close_err_s;
        end
    end

    // Statistics: count the closed packet once; a clear overrides the update
    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            good_r  <= {G_CNT_WIDTH{1'b0}};
            bad_r   <= {G_CNT_WIDTH{1'b0}};
            flags_r <= {ERR_W{1'b0}};
            done_r  <= 1'b0;
        end else if (clr_stats) begin
            good_r  <= {G_CNT_WIDTH{1'b0}};
            bad_r   <= {G_CNT_WIDTH{1'b0}};
            flags_r <= {ERR_W{1'b0}};
            done_r  <= 1'b0;
        end else if (close_pend_r) begin
            done_r  <= 1'b1;
            flags_r <= flags_r | close_err_r;
            if (|close_err_r) begin
                bad_r <= bad_r + CNT_ONE;
            end else begin
                good_r <= good_r + CNT_ONE;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign s_axis_tready = tready_r;
    assign good_pkt_cnt  = good_r;
    assign bad_pkt_cnt   = bad_r;
    assign err_flags     = flags_r;
    assign pkt_done      = done_r;

endmodule

// File: tb/tb_axis_packet_checker_400g.sv
// Directed, table-driven bench for axis_packet_checker_400g.
module tb_axis_packet_checker_400g;

    localparam int DW = 1024;
    localparam logic [15:0] SEED = 16'hACE1;

    logic            clk = 1'b0;
    logic            axis_aresetn = 1'b0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tready;
    logic [DW-1:0]   s_axis_tdata = '0;
    logic [DW/8-1:0] s_axis_tkeep = '1;
    logic            s_axis_tlast = 1'b0;
    logic            s_axis_tuser = 1'b0;
    logic            throttle_en = 1'b0;
    logic            clr_stats = 1'b0;
    logic [31:0]     good_pkt_cnt;
    logic [31:0]     bad_pkt_cnt;
    logic [4:0]      err_flags;
    logic            pkt_done;

    axis_packet_checker_400g #(
        .G_AXIS_DATA_WIDTH (DW),
        .G_PKT_BEATS       (64),
        .G_CNT_WIDTH       (32),
        .G_LFSR_SEED       (SEED)
    ) dut (
        .axis_aclk     (clk),
        .axis_aresetn  (axis_aresetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .throttle_en   (throttle_en),
        .clr_stats     (clr_stats),
        .good_pkt_cnt  (good_pkt_cnt),
        .bad_pkt_cnt   (bad_pkt_cnt),
        .err_flags     (err_flags),
        .pkt_done      (pkt_done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    int done_cnt  = 0;
    int pulse_err = 0;
    int tr_mis    = 0;
    int tr_zero   = 0;
    logic done_prev = 1'b0;
    logic [15:0] lfsr_m = SEED;
    logic exp_tready = 1'b0;

    // Reference ready: registered LFSR bit 0 (throttled) or constant 1
    always @(posedge clk) begin
        if (!axis_aresetn) begin
            lfsr_m     = SEED;
            exp_tready = 1'b0;
        end else begin
            exp_tready = throttle_en ? lfsr_m[0] : 1'b1;
            lfsr_m     = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
        end
    end

    // Output monitor: ready trace, pkt_done pulses and pulse width
    always @(negedge clk) begin
        if (s_axis_tready !== exp_tready) tr_mis++;
        if (throttle_en && !s_axis_tready) tr_zero++;
        if (pkt_done) begin
            done_cnt++;
            if (done_prev) pulse_err++;
        end
        done_prev = pkt_done;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // err_kind: 0 none, 1 data (+1), 2 keep bit 0 cleared, 3 tuser set
    task automatic send_pkt(input int n_len, input int n_send, input int err_beat, input int err_kind);
        int i = 0;
        int guard = 0;
        while (i < n_send && guard < 20000) begin
            @(negedge clk);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = '0;
            s_axis_tdata[15:0] = 16'(i);
            s_axis_tkeep  = '1;
            s_axis_tuser  = 1'b0;
            s_axis_tlast  = (i == n_len - 1);
            if (i == err_beat) begin
                case (err_kind)
                    1: s_axis_tdata[15:0] = 16'(i + 1);
                    2: s_axis_tkeep[0] = 1'b0;
                    3: s_axis_tuser = 1'b1;
                    default: ;
                endcase
            end
            if (s_axis_tready) i++;
            guard++;
        end
        if (i != n_send) check("send_beats", i, n_send);
    endtask

    task automatic wait_done(input string name, input int target);
        int guard = 0;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        while (done_cnt < target && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        check(name, done_cnt, target);
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
    endtask

    task automatic check_stats(input string tag, input int g, input int b, input int f);
        check({tag, "_good"}, good_pkt_cnt, g);
        check({tag, "_bad"}, bad_pkt_cnt, b);
        check({tag, "_flags"}, err_flags, f);
    endtask

    typedef struct {
        int n_len;
        int err_beat;
        int err_kind;
        bit thr;
        bit clr_before;
        int exp_good;
        int exp_bad;
        int exp_flags;
    } vec_t;

    vec_t tbl[17];

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int tgt;
        //            len  eb  ek thr clr good bad flags
        tbl[0]  = '{64, -1, 0, 0, 0, 1, 0, 5'h00};
        tbl[1]  = '{64, -1, 0, 0, 0, 2, 0, 5'h00};
        tbl[2]  = '{64, -1, 0, 0, 0, 3, 0, 5'h00};
        tbl[3]  = '{64, -1, 0, 1, 1, 1, 0, 5'h00};
        tbl[4]  = '{64, -1, 0, 1, 0, 2, 0, 5'h00};
        tbl[5]  = '{64, -1, 0, 1, 0, 3, 0, 5'h00};
        tbl[6]  = '{64, 10, 1, 0, 1, 0, 1, 5'h01};
        tbl[7]  = '{64, -1, 0, 0, 0, 1, 1, 5'h01};
        tbl[8]  = '{64,  5, 2, 0, 1, 0, 1, 5'h02};
        tbl[9]  = '{64, -1, 0, 0, 0, 1, 1, 5'h02};
        tbl[10] = '{40, -1, 0, 0, 1, 0, 1, 5'h08};
        tbl[11] = '{64, -1, 0, 0, 0, 1, 1, 5'h08};
        tbl[12] = '{70, -1, 0, 0, 1, 0, 1, 5'h10};
        tbl[13] = '{64, -1, 0, 0, 0, 1, 1, 5'h10};
        tbl[14] = '{ 1, -1, 0, 0, 1, 0, 1, 5'h08};
        tbl[15] = '{64,  3, 3, 0, 0, 0, 2, 5'h0C};
        tbl[16] = '{64, -1, 0, 0, 0, 1, 2, 5'h0C};

        // Reset state
        repeat (3) @(negedge clk);
        check_stats("reset", 0, 0, 0);
        check("reset_pkt_done", pkt_done, 0);
        check("reset_tready", s_axis_tready, 0);
        axis_aresetn = 1'b1;
        repeat (2) @(negedge clk);

        // Table of whole packets
        for (int k = 0; k < 17; k++) begin
            if (tbl[k].clr_before) clr_pulse();
            throttle_en = tbl[k].thr;
            tgt = done_cnt + 1;
            send_pkt(tbl[k].n_len, tbl[k].n_len, tbl[k].err_beat, tbl[k].err_kind);
            wait_done($sformatf("v%0d_done", k), tgt);
            check_stats($sformatf("v%0d", k), tbl[k].exp_good, tbl[k].exp_bad, tbl[k].exp_flags);
            if (k == 5) check("tready_low_seen", (tr_zero > 0), 1);
        end
        throttle_en = 1'b0;

        // Back-to-back clean packets
        clr_pulse();
        tgt = done_cnt + 2;
        send_pkt(64, 64, -1, 0);
        send_pkt(64, 64, -1, 0);
        wait_done("b2b_done", tgt);
        check_stats("b2b", 2, 0, 0);

        // Short packet immediately followed by a clean one
        tgt = done_cnt + 2;
        send_pkt(3, 3, -1, 0);
        send_pkt(64, 64, -1, 0);
        wait_done("b2b_short_done", tgt);
        check_stats("b2b_short", 3, 1, 5'h08);

        // Clear on the same edge as the counter update
        send_pkt(64, 64, -1, 0);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        clr_stats     = 1'b1;
        @(negedge clk);
        clr_stats     = 1'b0;
        repeat (4) @(negedge clk);
        check_stats("clr_coincide", 0, 0, 0);

        // Reset mid-packet, then a clean packet
        tgt = done_cnt + 1;
        send_pkt(64, 64, -1, 0);
        wait_done("pre_rst_done", tgt);
        send_pkt(64, 20, -1, 0);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        axis_aresetn  = 1'b0;
        repeat (2) @(negedge clk);
        check_stats("mid_rst", 0, 0, 0);
        check("mid_rst_pkt_done", pkt_done, 0);
        check("mid_rst_tready", s_axis_tready, 0);
        axis_aresetn = 1'b1;
        repeat (2) @(negedge clk);
        tgt = done_cnt + 1;
        send_pkt(64, 64, -1, 0);
        wait_done("post_rst_done", tgt);
        check_stats("post_rst", 1, 0, 0);

        check("tready_trace_mismatches", tr_mis, 0);
        check("pkt_done_wide_pulses", pulse_err, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
